// File: rtl/jam_param_solver_if.sv
// Bus between the job-assignment solver and its environment.
// Carries the run handshake (start/max_mode/valid/busy), the cost-ROM
// lookup (w/j out, cost back combinationally) and the result outputs.
//   master : host/ROM side - drives start, max_mode, cost
//   slave  : solver side   - drives w, j, min_cost, match_count, valid, busy
interface jam_param_solver_if #(
  parameter int IDXW = 3,
  parameter int CW   = 7,
  parameter int CNTW = 4
);
  logic                 start;
  logic                 max_mode;
  logic [IDXW-1:0]      w;
  logic [IDXW-1:0]      j;
  logic [CW-1:0]        cost;
  logic [CNTW-1:0]      match_count;
  logic [CW+IDXW-1:0]   min_cost;
  logic                 valid;
  logic                 busy;

  modport master (
    output start, max_mode, cost,
    input  w, j, match_count, min_cost, valid, busy
  );

  modport slave (
    input  start, max_mode, cost,
    output w, j, match_count, min_cost, valid, busy
  );
endinterface

// File: rtl/jam_param_solver.sv
// Exhaustive job-assignment solver. Walks all N! worker->job permutations
// in lexicographic order, sums the cost of each from an external
// combinational cost ROM, and reports the optimum (min or max) total and
// how many permutations reach it (saturating count).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; aborts any run without valid
//   bus  - jam_param_solver_if slave: start/max_mode in, w/j out to ROM,
//          cost in, min_cost/match_count/valid/busy out (all registered)
module jam_param_solver #(
  parameter int N          = 8,
  parameter int IDXW       = 3,
  parameter int CW         = 7,
  parameter int CNTW       = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  jam_param_solver_if.slave bus
);

  localparam int              SW   = CW + IDXW;
  localparam int unsigned     NU   = N;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    CMP,
    PIVOT,
    SWAP,
    REV,
    DONE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] perm [N];
  logic [IDXW-1:0] k;
  logic [IDXW-1:0] piv;
  logic [SW-1:0]   sum;
  logic [SW-1:0]   best;
  logic [CNTW-1:0] count;
  logic            mode;
  logic            auto_pending;

  logic            descending;
  logic [IDXW-1:0] pivot_idx;
  logic [IDXW-1:0] swap_idx;
  logic [IDXW-1:0] rev_perm [N];
  logic            better;
  logic [SW-1:0]   next_best;
  logic [CNTW-1:0] next_count;

  // Next-permutation helpers and the CMP-stage result update.
  always_comb begin
    descending = 1'b1;
    pivot_idx  = '0;
    for (int unsigned x = 0; x < NU - 1; x++) begin
      if (perm[IDXW'(x)] < perm[IDXW'(x + 1)]) begin
        descending = 1'b0;
        pivot_idx  = IDXW'(x);
      end
    end

    swap_idx = piv;
    for (int unsigned x = 0; x < NU; x++) begin
      if ((IDXW'(x) > piv) && (perm[IDXW'(x)] > perm[piv]))
        swap_idx = IDXW'(x);
    end

    // Tail piv+1..N-1 is reversed in place: position x takes the element
    // mirrored about the tail centre, index (N-1)+(piv+1)-x.
    for (int unsigned x = 0; x < NU; x++) begin
      if (IDXW'(x) > piv)
        rev_perm[IDXW'(x)] = perm[LAST + piv + IDXW'(1) - IDXW'(x)];
      else
        rev_perm[IDXW'(x)] = perm[IDXW'(x)];
    end

    better    = mode ? (sum > best) : (sum < best);
    next_best = better ? sum : best;
    if (better)
      next_count = CNTW'(1);
    else if ((sum == best) && (count != '1))
      next_count = count + CNTW'(1);
    else
      next_count = count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      for (int unsigned x = 0; x < NU; x++)
        perm[IDXW'(x)] <= IDXW'(x);
      k            <= '0;
      piv          <= '0;
      sum          <= '0;
      best         <= '0;
      count        <= '0;
      mode         <= 1'b0;
      auto_pending <= AUTO_START;
      bus.w           <= '0;
      bus.j           <= '0;
      bus.min_cost    <= '0;
      bus.match_count <= '0;
      bus.valid       <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start || auto_pending) begin
            auto_pending <= 1'b0;
            for (int unsigned x = 0; x < NU; x++)
              perm[IDXW'(x)] <= IDXW'(x);
            sum      <= '0;
            count    <= '0;
            mode     <= bus.max_mode;
            best     <= bus.max_mode ? '0 : '1;
            k        <= '0;
            bus.w    <= '0;
            bus.j    <= '0;
            bus.busy <= 1'b1;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          sum <= sum + SW'(bus.cost);
          if (k == LAST) begin
            state <= CMP;
          end else begin
            k     <= k + IDXW'(1);
            bus.w <= k + IDXW'(1);
            bus.j <= perm[k + IDXW'(1)];
          end
        end

        CMP: begin
          best  <= next_best;
          count <= next_count;
          sum   <= '0;
          if (descending) begin
            bus.min_cost    <= next_best;
            bus.match_count <= next_count;
            bus.valid       <= 1'b1;
            state           <= DONE;
          end else begin
            state <= PIVOT;
          end
        end

        PIVOT: begin
          piv   <= pivot_idx;
          state <= SWAP;
        end

        SWAP: begin
          perm[piv]      <= perm[swap_idx];
          perm[swap_idx] <= perm[piv];
          state          <= REV;
        end

        REV: begin
          for (int unsigned x = 0; x < NU; x++)
            perm[IDXW'(x)] <= rev_perm[IDXW'(x)];
          // perm[0] is never inside the reversed tail, so it is already final.
          k     <= '0;
          bus.w <= '0;
          bus.j <= perm[0];
          state <= ACCUM;
        end

        DONE: begin
          bus.valid <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_param_solver.sv
// Self-checking bench for jam_param_solver: several instances with
// different sizes, a scoreboard of expected results/latencies, and
// per-cycle range and valid-pulse monitoring.
module tb_jam_param_solver;

  logic       clk;
  logic [4:0] rst_v;
  logic [4:0] start_v;
  logic [4:0] mode_v;
  int unsigned cyc;
  int checks;
  int errors;

  int tab [5][8][8];

  typedef struct {
    int          id;
    int unsigned cost;
    int unsigned cnt;
    int unsigned lat;
    int unsigned stamp;
  } exp_t;
  exp_t exp_q[$];

  int range_bad [5];
  int dbl_valid [5];
  int vcnt      [5];
  logic prev_v  [5];
  int p8 [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // instance 0: N=8 autostart; 1: N=4 CNTW=5; 2: N=4 CNTW=4; 3: N=3; 4: N=6
  jam_param_solver_if #(.IDXW(3), .CW(7), .CNTW(4)) if0 ();
  jam_param_solver_if #(.IDXW(2), .CW(7), .CNTW(5)) if1 ();
  jam_param_solver_if #(.IDXW(2), .CW(7), .CNTW(4)) if2 ();
  jam_param_solver_if #(.IDXW(2), .CW(7), .CNTW(4)) if3 ();
  jam_param_solver_if #(.IDXW(3), .CW(7), .CNTW(4)) if4 ();

  assign if0.start = start_v[0];  assign if0.max_mode = mode_v[0];
  assign if1.start = start_v[1];  assign if1.max_mode = mode_v[1];
  assign if2.start = start_v[2];  assign if2.max_mode = mode_v[2];
  assign if3.start = start_v[3];  assign if3.max_mode = mode_v[3];
  assign if4.start = start_v[4];  assign if4.max_mode = mode_v[4];

  always_comb if0.cost = 7'((int'(if0.w) * 7 + int'(if0.j) * 3) % 97);
  assign if1.cost = 7'd5;
  assign if2.cost = 7'd5;
  always_comb if3.cost = 7'(tab[3][if3.w][if3.j]);
  always_comb if4.cost = 7'(tab[4][if4.w][if4.j]);

  jam_param_solver #(.N(8), .IDXW(3), .CW(7), .CNTW(4), .AUTO_START(1'b1))
    u0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
  jam_param_solver #(.N(4), .IDXW(2), .CW(7), .CNTW(5), .AUTO_START(1'b0))
    u1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
  jam_param_solver #(.N(4), .IDXW(2), .CW(7), .CNTW(4), .AUTO_START(1'b0))
    u2 (.clk(clk), .rst(rst_v[2]), .bus(if2));
  jam_param_solver #(.N(3), .IDXW(2), .CW(7), .CNTW(4), .AUTO_START(1'b0))
    u3 (.clk(clk), .rst(rst_v[3]), .bus(if3));
  jam_param_solver #(.N(6), .IDXW(3), .CW(7), .CNTW(4), .AUTO_START(1'b0))
    u4 (.clk(clk), .rst(rst_v[4]), .bus(if4));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic on_valid(int id, logic [63:0] cost, logic [63:0] cnt, logic busy);
    exp_t e;
    chk($sformatf("sb_pending_u%0d", id), 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk($sformatf("sb_id_u%0d", id), 64'(id), 64'(e.id));
      chk($sformatf("min_cost_u%0d", id), cost, 64'(e.cost));
      chk($sformatf("match_count_u%0d", id), cnt, 64'(e.cnt));
      chk($sformatf("latency_u%0d", id), 64'(cyc - e.stamp + 1), 64'(e.lat));
      chk($sformatf("busy_at_valid_u%0d", id), 64'(busy), 64'd1);
    end
  endtask

  task automatic mon(int id, int n, int w, int j, logic valid, logic busy,
                     logic [63:0] cost, logic [63:0] cnt);
    if (w >= n || j >= n) range_bad[id]++;
    if (valid && prev_v[id]) dbl_valid[id]++;
    if (valid) begin
      vcnt[id]++;
      on_valid(id, cost, cnt, busy);
    end
    prev_v[id] = valid;
  endtask

  always @(negedge clk) begin
    mon(0, 8, int'(if0.w), int'(if0.j), if0.valid, if0.busy, 64'(if0.min_cost), 64'(if0.match_count));
    mon(1, 4, int'(if1.w), int'(if1.j), if1.valid, if1.busy, 64'(if1.min_cost), 64'(if1.match_count));
    mon(2, 4, int'(if2.w), int'(if2.j), if2.valid, if2.busy, 64'(if2.min_cost), 64'(if2.match_count));
    mon(3, 3, int'(if3.w), int'(if3.j), if3.valid, if3.busy, 64'(if3.min_cost), 64'(if3.match_count));
    mon(4, 6, int'(if4.w), int'(if4.j), if4.valid, if4.busy, 64'(if4.min_cost), 64'(if4.match_count));
  end

  // Start pulse sampled at exactly one rising edge; stamp taken in cycle 1.
  task automatic pulse(int id, bit mode, bit push, int unsigned ecost,
                       int unsigned ecnt, int unsigned elat);
    @(negedge clk);
    start_v[id] = 1'b1;
    mode_v[id]  = mode;
    @(negedge clk);
    start_v[id] = 1'b0;
    if (push) exp_q.push_back('{id, ecost, ecnt, elat, cyc});
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic adv_perm();
    int i, j, t;
    i = 6;
    while (i >= 0 && p8[i] > p8[i + 1]) i--;
    j = 7;
    while (p8[j] < p8[i]) j--;
    t = p8[i]; p8[i] = p8[j]; p8[j] = t;
    for (int a = i + 1, b = 7; a < b; a++, b--) begin
      t = p8[a]; p8[a] = p8[b]; p8[b] = t;
    end
  endtask

  // Brute force over all n^n index tuples, keeping only true permutations.
  function automatic void model(int id, int n, bit mx, int cntw,
                                output int unsigned best, output int unsigned cnt);
    int total, c, jj;
    int unsigned s;
    bit used [8];
    bit okp;
    best  = mx ? 0 : 32'hFFFF_FFFF;
    cnt   = 0;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    for (int code = 0; code < total; code++) begin
      c = code;
      okp = 1'b1;
      s = 0;
      for (int i = 0; i < 8; i++) used[i] = 1'b0;
      for (int w = 0; w < n; w++) begin
        jj = c % n;
        c  = c / n;
        if (used[jj]) okp = 1'b0;
        used[jj] = 1'b1;
        s += tab[id][w][jj];
      end
      if (okp) begin
        if (mx ? (s > best) : (s < best)) begin
          best = s;
          cnt  = 1;
        end else if (s == best) begin
          cnt++;
        end
      end
    end
    if (cnt > (1 << cntw) - 1) cnt = (1 << cntw) - 1;
  endfunction

  initial begin
    int n;
    int unsigned eb, ec;
    rst_v   = '1;
    start_v = '0;
    mode_v  = '0;
    checks  = 0;
    errors  = 0;
    for (int i = 0; i < 5; i++) begin
      range_bad[i] = 0; dbl_valid[i] = 0; vcnt[i] = 0; prev_v[i] = 1'b0;
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) tab[i][a][b] = 0;
    end
    repeat (3) @(negedge clk);

    chk("rst_busy_u0", 64'(if0.busy), 64'd0);
    chk("rst_valid_u0", 64'(if0.valid), 64'd0);
    chk("rst_cost_u0", 64'(if0.min_cost), 64'd0);
    chk("rst_cnt_u0", 64'(if0.match_count), 64'd0);
    chk("rst_wj_u0", 64'({if0.w, if0.j}), 64'd0);
    chk("rst_busy_u1", 64'(if1.busy), 64'd0);

    rst_v = '0;
    // AUTO_START instance walks identity, then the next two permutations.
    for (int i = 0; i < 8; i++) p8[i] = i;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("u0_w_p%0d_k%0d", p, k), 64'(if0.w), 64'(k));
        chk($sformatf("u0_j_p%0d_k%0d", p, k), 64'(if0.j), 64'(p8[k]));
        chk("u0_busy", 64'(if0.busy), 64'd1);
      end
      if (p < 2) begin
        repeat (4) @(negedge clk);
        adv_perm();
      end
    end
    @(negedge clk);
    rst_v[0] = 1'b1;
    #1;
    chk("u0_abort_busy", 64'(if0.busy), 64'd0);
    chk("u0_abort_wj", 64'({if0.w, if0.j}), 64'd0);
    chk("u1_no_autostart", 64'(if1.busy), 64'd0);

    // all-5 tables: every permutation ties
    pulse(1, 1'b0, 1'b1, 20, 24, 190);
    drain(400);
    chk("u1_busy_after", 64'(if1.busy), 64'd0);
    pulse(2, 1'b0, 1'b1, 20, 15, 190);
    drain(400);

    // N=3 identity-only zero diagonal; extra Start mid-run is ignored
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) tab[3][a][b] = (a == b) ? 0 : 9;
    pulse(3, 1'b0, 1'b1, 0, 1, 40);
    repeat (15) @(negedge clk);
    pulse(3, 1'b1, 1'b0, 0, 0, 0);
    n = 0;
    while (!if3.valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("u3_valid_seen", 64'(if3.valid), 64'd1);
    // Start held across the DONE edge only: must not launch a run
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    chk("u3_done_start_idle", 64'(if3.busy), 64'd0);
    @(negedge clk);
    chk("u3_done_start_ignored", 64'(if3.busy), 64'd0);
    drain(5);

    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) tab[3][a][b] = a * 3 + b;
    pulse(3, 1'b1, 1'b1, 12, 6, 40);
    drain(100);
    pulse(3, 1'b0, 1'b1, 12, 6, 40);
    drain(100);

    // reset mid-run clears outputs immediately and suppresses valid
    pulse(3, 1'b0, 1'b0, 0, 0, 0);
    repeat (10) @(negedge clk);
    chk("u3_hold_cost", 64'(if3.min_cost), 64'd12);
    chk("u3_hold_busy", 64'(if3.busy), 64'd1);
    rst_v[3] = 1'b1;
    #1;
    chk("u3_rst_cost", 64'(if3.min_cost), 64'd0);
    chk("u3_rst_cnt", 64'(if3.match_count), 64'd0);
    chk("u3_rst_busy", 64'(if3.busy), 64'd0);
    chk("u3_rst_valid", 64'(if3.valid), 64'd0);
    @(negedge clk);
    rst_v[3] = 1'b0;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++) tab[3][a][b] = (a == b) ? 9 : 0;
    pulse(3, 1'b0, 1'b1, 0, 2, 40);
    drain(100);
    pulse(3, 1'b1, 1'b1, 27, 1, 40);
    drain(100);

    // N=6 random tables against the brute-force model
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 6; a++)
        for (int b = 0; b < 6; b++)
          tab[4][a][b] = (r < 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
      model(4, 6, r == 1, 4, eb, ec);
      pulse(4, r == 1, 1'b1, eb, ec, 7198);
      drain(7300);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("range_u%0d", i), 64'(range_bad[i]), 64'd0);
      chk($sformatf("double_valid_u%0d", i), 64'(dbl_valid[i]), 64'd0);
    end
    chk("valid_count_u0", 64'(vcnt[0]), 64'd0);
    chk("valid_count_u1", 64'(vcnt[1]), 64'd1);
    chk("valid_count_u2", 64'(vcnt[2]), 64'd1);
    chk("valid_count_u3", 64'(vcnt[3]), 64'd5);
    chk("valid_count_u4", 64'(vcnt[4]), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
